// File: rtl/de1_pkg.sv
// Board-level constants for the DE1 key/switch inputs and the conditioner defaults derived from them.
package de1_pkg;

   localparam int unsigned CLK_HZ      = 50_000_000;
   localparam int unsigned DEBOUNCE_MS = 10;
   localparam int unsigned N_KEY       = 4;
   localparam int unsigned N_SW        = 10;
   localparam int unsigned DE1_N_CH    = N_KEY + N_SW;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int unsigned DEF_SYNC_STAGES     = 2;

   // Keys sit in the low bits and are wired active-low on the board; switches are active-high.
   localparam logic [DE1_N_CH-1:0] DEF_ACTIVE_LOW = DE1_N_CH'({N_KEY{1'b1}});

   // Registered per-channel results of one debouncer.
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
      logic toggle;
   } ch_out_t;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 1) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioned input: synchronizer, debounce counter, accepted level, edge pulses and toggle.
module debounce_ch
   import de1_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic    clock_50,
   input  logic    reset,
   input  logic    raw_in,
   output ch_out_t ch_out,
   output logic    rise_c
);

   localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("debounce_ch: DEBOUNCE_CYCLES must be at least 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("debounce_ch: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   toggle_q, toggle_d;
   logic                   s;

   // Plain shift chain; nothing may sit between the synchronizer flops.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
   end

   // Count consecutive cycles of disagreement; accept on the last one, restart on any agreement.
   always_comb begin
      s        = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
      cnt_d    = '0;
      level_d  = level_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      toggle_d = toggle_q;
      if (s != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d  = s;
            rise_d   = s;
            fall_d   = ~s;
            toggle_d = toggle_q ^ s;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer resets to the idle raw level so reset release never looks like a press.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         sync_q   <= {SYNC_STAGES{ACTIVE_LOW}};
         cnt_q    <= '0;
         level_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         toggle_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         toggle_q <= toggle_d;
      end
   end

   assign ch_out.level  = level_q;
   assign ch_out.rise   = rise_q;
   assign ch_out.fall   = fall_q;
   assign ch_out.toggle = toggle_q;
   assign rise_c        = rise_d;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the DE1 keys and switches: N_CH independent debouncers plus a registered any-rise flag.
module input_conditioner
   import de1_pkg::*;
#(
   parameter int unsigned       N_CH            = DE1_N_CH,
   parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned       SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter logic [N_CH-1:0]   ACTIVE_LOW      = N_CH'(DEF_ACTIVE_LOW)
) (
   input  logic            clock_50,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] toggle,
   output logic            any_rise
);

   ch_out_t         ch_out [N_CH];
   logic [N_CH-1:0] rise_c;
   logic            any_rise_q, any_rise_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES),
         .ACTIVE_LOW      (ACTIVE_LOW[i])
      ) u_ch (
         .clock_50 (clock_50),
         .reset    (reset),
         .raw_in   (raw_in[i]),
         .ch_out   (ch_out[i]),
         .rise_c   (rise_c[i])
      );

      assign level[i]  = ch_out[i].level;
      assign rise[i]   = ch_out[i].rise;
      assign fall[i]   = ch_out[i].fall;
      assign toggle[i] = ch_out[i].toggle;
   end

   // Built from the next-state rise bits so the flag lands in the same cycle as the pulses.
   always_comb begin
      any_rise_d = |rise_c;
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         any_rise_q <= 1'b0;
      end else begin
         any_rise_q <= any_rise_d;
      end
   end

   assign any_rise = any_rise_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: DEBOUNCE_CYCLES=4 and =1 builds against a cycle-level behavioural model.
module tb_input_conditioner;

   localparam int unsigned N  = 14;
   localparam int unsigned SS = 2;
   localparam logic [N-1:0] AL = 14'h00F;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] raw;

   logic [N-1:0] level4, rise4, fall4, toggle4;
   logic         any4;
   logic [N-1:0] level1, rise1, fall1, toggle1;
   logic         any1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   input_conditioner #(
      .N_CH(N), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(SS), .ACTIVE_LOW(AL)
   ) dut4 (
      .clock_50(clk), .reset(reset), .raw_in(raw),
      .level(level4), .rise(rise4), .fall(fall4), .toggle(toggle4), .any_rise(any4)
   );

   input_conditioner #(
      .N_CH(N), .DEBOUNCE_CYCLES(1), .SYNC_STAGES(SS), .ACTIVE_LOW(AL)
   ) dut1 (
      .clock_50(clk), .reset(reset), .raw_in(raw),
      .level(level1), .rise(rise1), .fall(fall1), .toggle(toggle1), .any_rise(any1)
   );

   // Reference model: index 0 models the 4-cycle build, index 1 the 1-cycle build.
   int unsigned  dcy [2] = '{4, 1};
   logic [N-1:0] hist [2][SS];
   logic [N-1:0] m_level [2];
   logic [N-1:0] m_rise [2];
   logic [N-1:0] m_fall [2];
   logic [N-1:0] m_toggle [2];
   logic         m_any [2];
   int unsigned  run [2][N];

   task automatic model_edge();
      logic [N-1:0] s;
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            for (int k = 0; k < SS; k++) hist[m][k] = '0;
            m_level[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_toggle[m] = '0; m_any[m] = 1'b0;
            for (int c = 0; c < N; c++) run[m][c] = 0;
         end else begin
            s = hist[m][SS-1];
            for (int k = SS - 1; k > 0; k--) hist[m][k] = hist[m][k-1];
            hist[m][0] = raw ^ AL;
            m_rise[m] = '0;
            m_fall[m] = '0;
            for (int c = 0; c < N; c++) begin
               if (s[c] != m_level[m][c]) begin
                  run[m][c]++;
                  if (run[m][c] == dcy[m]) begin
                     m_level[m][c] = s[c];
                     if (s[c]) m_rise[m][c] = 1'b1;
                     else      m_fall[m][c] = 1'b1;
                     run[m][c] = 0;
                  end
               end else begin
                  run[m][c] = 0;
               end
            end
            m_toggle[m] = m_toggle[m] ^ m_rise[m];
            m_any[m]    = |m_rise[m];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("d4.level",  level4,  m_level[0]);
      chk("d4.rise",   rise4,   m_rise[0]);
      chk("d4.fall",   fall4,   m_fall[0]);
      chk("d4.toggle", toggle4, m_toggle[0]);
      chk("d4.any",    N'(any4), N'(m_any[0]));
      chk("d1.level",  level1,  m_level[1]);
      chk("d1.rise",   rise1,   m_rise[1]);
      chk("d1.fall",   fall1,   m_fall[1]);
      chk("d1.toggle", toggle1, m_toggle[1]);
      chk("d1.any",    N'(any1), N'(m_any[1]));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      check_model();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int r1, f1;
   int idx;

   initial begin
      reset = 1'b1;
      raw   = AL;
      steps(3);
      chk("reset_level",  level4,  '0);
      chk("reset_toggle", toggle4, '0);
      chk("reset_any",    N'(any4), '0);

      // Release of reset with idle inputs must stay quiet.
      reset = 1'b0;
      steps(8);
      chk("release_quiet", rise4 | fall4 | level4, '0);

      // Clean press on key0: accepted on the 6th edge counting the sampling edge.
      raw[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("key0_early", N'(rise4[0]), '0);
      end
      step();
      chk("key0_rise",   N'(rise4[0]),   N'(1));
      chk("key0_level",  N'(level4[0]),  N'(1));
      chk("key0_toggle", N'(toggle4[0]), N'(1));
      chk("key0_any",    N'(any4),       N'(1));
      step();
      chk("key0_single", N'(rise4[0]),   '0);
      steps(13);

      // Bounce on sw0: short pulses rejected, final stable level accepted.
      for (int i = 0; i < 4; i++) begin
         raw[4] = ~raw[4];
         for (int k = 0; k < 2; k++) begin
            step();
            chk("sw0_bounce", N'(rise4[4] | fall4[4] | level4[4]), '0);
         end
      end
      raw[4] = 1'b1;
      steps(5);
      chk("sw0_pre", N'(level4[4]), '0);
      step();
      chk("sw0_rise", N'(rise4[4]), N'(1));
      steps(10);

      // Press / release / press on key1.
      for (int ph = 0; ph < 3; ph++) begin
         raw[1] = (ph == 1);
         r1 = 0; f1 = 0;
         for (int i = 0; i < 10; i++) begin
            step();
            r1 += int'(rise4[1]);
            f1 += int'(fall4[1]);
         end
         chk("key1_rises", N'(r1), N'((ph == 1) ? 0 : 1));
         chk("key1_falls", N'(f1), N'((ph == 1) ? 1 : 0));
         chk("key1_toggle", N'(toggle4[1]), N'((ph == 2) ? 0 : 1));
      end

      // Reset part-way through key2's count.
      raw[2] = 1'b0;
      steps(4);
      reset = 1'b1;
      step();
      chk("rst_level",  level4,  '0);
      chk("rst_toggle", toggle4, '0);
      reset = 1'b0;
      steps(5);
      chk("key2_pre", N'(level4[2]), '0);
      step();
      chk("key2_level", N'(level4[2]), N'(1));
      steps(6);

      // All channels go active on one edge.
      raw = AL;
      steps(12);
      raw = ~AL;
      steps(5);
      step();
      chk("all_rise",  rise4,    14'h3FFF);
      chk("all_level", level4,   14'h3FFF);
      chk("all_any",   N'(any4), N'(1));
      step();
      chk("all_any_off", N'(any4), '0);
      steps(6);

      // Single-cycle glitch on sw9 through the 1-cycle build.
      raw[13] = 1'b0;
      steps(10);
      raw[13] = 1'b1;
      step();
      raw[13] = 1'b0;
      step();
      step();
      chk("sw9_rise",  N'(rise1[13]),  N'(1));
      chk("sw9_level", N'(level1[13]), N'(1));
      step();
      chk("sw9_fall",  N'(fall1[13]),  N'(1));
      chk("sw9_low",   N'(level1[13]), '0);
      chk("sw9_d4",    N'(level4[13]), '0);
      steps(4);

      // Random walk with occasional reset pulses.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            idx = int'($urandom_range(N - 1, 0));
            raw[idx] = ~raw[idx];
         end
         reset = ($urandom_range(199, 0) == 0);
         step();
      end
      reset = 1'b0;
      steps(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
